// File: rtl/user_pattern_sequencer_if.sv
// Sample-bus bundle for the user test pattern sequencer: pattern-register inputs
// toward the sequencer and the pattern sample stream back out.
interface user_pattern_sequencer_if #(
    parameter int DATA_W = 14
);
    logic              in_enable;
    logic              in_repeat;
    logic [1:0]        in_num_pat;
    logic [15:0]       in_pattern1;
    logic [15:0]       in_pattern2;
    logic [15:0]       in_pattern3;
    logic [15:0]       in_pattern4;
    // out_valid qualifies out_data/out_index on every cycle; there is no backpressure.
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [1:0]        out_index;
    logic              out_busy;
    logic              out_done;

    modport master (
        output in_enable, in_repeat, in_num_pat,
        output in_pattern1, in_pattern2, in_pattern3, in_pattern4,
        input  out_data, out_valid, out_index, out_busy, out_done
    );

    modport slave (
        input  in_enable, in_repeat, in_num_pat,
        input  in_pattern1, in_pattern2, in_pattern3, in_pattern4,
        output out_data, out_valid, out_index, out_busy, out_done
    );
endinterface

// File: rtl/user_pattern_sequencer.sv
// AD9643-style user test pattern sequencer: plays the four latched pattern words
// onto the sample bus, single-shot or continuously, each word held HOLD_CYCLES clocks.
module user_pattern_sequencer #(
    parameter int DATA_W      = 14,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    user_pattern_sequencer_if.slave bus,
    output logic [1:0]              dbgState
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT             state;
    stateT             nextState;
    logic [CNT_W-1:0]  holdCnt;
    logic [1:0]        idx;
    logic [15:0]       shPat [4];
    logic [1:0]        shNum;
    logic              shRepeat;
    logic              armed;

    logic holdEnd;
    logic lastWord;
    logic startRun;
    logic loadShadow;

    assign holdEnd  = (holdCnt == HOLD_LAST);
    assign lastWord = holdEnd && (idx == shNum);
    assign startRun = (state == IDLE) && bus.in_enable && armed;
    // Shadow words only change at a sequence start or at a repeat wrap boundary.
    assign loadShadow = startRun ||
                        ((state == RUN) && bus.in_enable && lastWord && shRepeat);
    assign dbgState = state;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (bus.in_enable && armed) nextState = RUN;
            RUN: begin
                if (!bus.in_enable)             nextState = IDLE;
                else if (lastWord && !shRepeat) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            holdCnt  <= '0;
            idx      <= '0;
            shNum    <= '0;
            shRepeat <= 1'b0;
            armed    <= 1'b1;
            for (int i = 0; i < 4; i++) shPat[i] <= '0;
        end else begin
            // A held-high enable must be seen low before another run can start.
            if (!bus.in_enable) armed <= 1'b1;
            else if (startRun)  armed <= 1'b0;

            if (loadShadow) begin
                shPat[0] <= bus.in_pattern1;
                shPat[1] <= bus.in_pattern2;
                shPat[2] <= bus.in_pattern3;
                shPat[3] <= bus.in_pattern4;
                shNum    <= bus.in_num_pat;
            end
            if (startRun) shRepeat <= bus.in_repeat;

            if ((state == RUN) && bus.in_enable) begin
                if (holdEnd) begin
                    holdCnt <= '0;
                    idx     <= (idx == shNum) ? 2'd0 : idx + 2'd1;
                end else begin
                    holdCnt <= holdCnt + CNT_W'(1);
                end
            end else begin
                holdCnt <= '0;
                idx     <= '0;
            end
        end
    end

    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = 1'b0;
        bus.out_index = 2'd0;
        bus.out_busy  = 1'b0;
        bus.out_done  = 1'b0;
        case (state)
            RUN: begin
                bus.out_data  = shPat[idx][15 -: DATA_W];
                bus.out_valid = 1'b1;
                bus.out_index = idx;
                bus.out_busy  = 1'b1;
            end
            DONE:    bus.out_done = 1'b1;
            default: ;
        endcase
    end
endmodule
